// File: rtl/autoc_pkg.sv
// Shared definitions for the autocorrelation preamble generator: state encoding,
// sample width and the constants of the optional LFSR pattern source.
package autoc_pkg;

    localparam int unsigned DDC_SAMPLE_WIDTH = 32;

    // Fibonacci LFSR x^7 + x^6 + 1: feedback taps on bits 6 and 5.
    localparam logic [6:0]  LFSR_TAPS     = 7'h60;
    localparam logic [6:0]  LFSR_SEED     = 7'h7F;
    localparam logic [15:0] LFSR_AMP      = 16'h4000;
    localparam logic [15:0] LFSR_AMP_NEG  = 16'hC000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StGap  = 2'd3
    } autoc_state_e;

    // One shift of the LFSR; the MSB is the output bit.
    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[5:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/autoc_pattern_ram.sv
// Pattern store: DEPTH x DW words, one write port, synchronous single-cycle read.
// Contents are deliberately not reset.
module autoc_pattern_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    // Host write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read: data appears the cycle after the address.
    always_ff @(posedge clk_i) begin
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/autoc_preamble_gen.sv
// Periodic training preamble generator feeding the TX DUC chain.
// Emits PERIOD-sample pattern repeated `reps` times, then GAP_LEN zero samples.
// Optional feature macro: AUTOC_PREAMBLE_LFSR_EN (BPSK LFSR pattern instead of RAM).
module autoc_preamble_gen
    import autoc_pkg::*;
#(
    parameter int unsigned PERIOD  = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned GAP_LEN = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [7:0]                  reps,
    input  logic                        cfg_we,
    input  logic [AW-1:0]               cfg_addr,
    input  logic [DDC_SAMPLE_WIDTH-1:0] cfg_data,
`ifdef AUTOC_PREAMBLE_LFSR_EN
    input  logic                        use_lfsr,
`endif
    input  logic                        duc_in_strobe,
    output logic                        duc_in_enable,
    output logic [DDC_SAMPLE_WIDTH-1:0] duc_in_sample,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned GapW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    autoc_state_e state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [7:0]      rep_q, rep_d;
    logic [7:0]      reps_q, reps_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            done_q, done_d;

    logic [AW-1:0]               rd_addr;
    logic [DDC_SAMPLE_WIDTH-1:0] ram_rdata;
    logic                        ram_we;

`ifdef AUTOC_PREAMBLE_LFSR_EN
    logic       use_lfsr_q, use_lfsr_d;
    logic [6:0] lfsr_q, lfsr_d;
`endif

    // Pattern writes are dropped during a burst so the output stays stable.
    assign ram_we = cfg_we & (state_q == StIdle);

    autoc_pattern_ram #(
        .DEPTH (PERIOD),
        .AW    (AW),
        .DW    (DDC_SAMPLE_WIDTH)
    ) u_ram (
        .clk_i     (clk),
        .we_i      (ram_we),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_rdata)
    );

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            rep_q   <= '0;
            reps_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            reps_q  <= reps_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

`ifdef AUTOC_PREAMBLE_LFSR_EN
    // LFSR mode flag and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            use_lfsr_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            use_lfsr_q <= use_lfsr_d;
            lfsr_q     <= lfsr_d;
        end
    end
`endif

    // Next-state logic. The read address runs one ahead of idx on a strobe so
    // back-to-back strobes see a fresh word every cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        reps_d  = reps_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        rd_addr = idx_q;
`ifdef AUTOC_PREAMBLE_LFSR_EN
        use_lfsr_d = use_lfsr_q;
        lfsr_d     = lfsr_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StLoad;
                    reps_d  = reps;
                    idx_d   = '0;
                    rep_d   = '0;
                    gap_d   = '0;
`ifdef AUTOC_PREAMBLE_LFSR_EN
                    use_lfsr_d = use_lfsr;
`endif
                end
            end

            StLoad: begin
                rd_addr = '0;
`ifdef AUTOC_PREAMBLE_LFSR_EN
                lfsr_d  = LFSR_SEED;
`endif
                state_d = (reps_q == 8'd0) ? StGap : StRun;
            end

            StRun: begin
                if (duc_in_strobe) begin
                    if (idx_q == AW'(PERIOD - 1)) begin
                        idx_d   = '0;
                        rep_d   = rep_q + 8'd1;
                        rd_addr = '0;
`ifdef AUTOC_PREAMBLE_LFSR_EN
                        // Reseed per repetition keeps the sequence PERIOD-periodic.
                        lfsr_d  = LFSR_SEED;
`endif
                        if (rep_q == reps_q - 8'd1) begin
                            state_d = StGap;
                        end
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        rd_addr = idx_q + AW'(1);
`ifdef AUTOC_PREAMBLE_LFSR_EN
                        lfsr_d  = lfsr_step(lfsr_q);
`endif
                    end
                end
            end

            StGap: begin
                if (duc_in_strobe) begin
                    if (gap_q == GapW'(GAP_LEN - 1)) begin
                        state_d = StIdle;
                        gap_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        gap_d = gap_q + GapW'(1);
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        // Abort beats everything, including a same-cycle start or completion.
        if (abort) begin
            state_d = StIdle;
            idx_d   = '0;
            rep_d   = '0;
            gap_d   = '0;
            done_d  = 1'b0;
        end
    end

    // Output drive: samples only in RUN, zero elsewhere.
    always_comb begin
        busy          = (state_q != StIdle);
        duc_in_enable = busy;
        done          = done_q;
        duc_in_sample = '0;
        if (state_q == StRun) begin
`ifdef AUTOC_PREAMBLE_LFSR_EN
            if (use_lfsr_q) begin
                duc_in_sample = {(lfsr_q[6] ? LFSR_AMP_NEG : LFSR_AMP), 16'h0000};
            end else begin
                duc_in_sample = ram_rdata;
            end
`else
            duc_in_sample = ram_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_autoc_preamble_gen.sv
// Directed, scoreboard-based bench for autoc_preamble_gen (default build).
module tb_autoc_preamble_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  reps;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        use_lfsr;
    logic        duc_in_strobe;
    logic        duc_in_enable;
    logic [31:0] duc_in_sample;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    autoc_preamble_gen #(
        .PERIOD  (32),
        .AW      (5),
        .GAP_LEN (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .reps          (reps),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
`ifdef AUTOC_PREAMBLE_LFSR_EN
        .use_lfsr      (use_lfsr),
`endif
        .duc_in_strobe (duc_in_strobe),
        .duc_in_enable (duc_in_enable),
        .duc_in_sample (duc_in_sample),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        logic [15:0] v;
        v = 16'(k);
        return {v, ~v};
    endfunction

    function automatic logic [31:0] status();
        return {29'b0, busy, duc_in_enable, done};
    endfunction

    // One burst: fill scoreboard, start, strobe every `stride` cycles, compare
    // each presented sample to the scoreboard head, optionally abort or poke.
    task automatic run_burst(input int r, input int stride, input int abort_at,
                             input bit poke, input string tag);
        int  cyc;
        int  strobes;
        bit  fin;
        bit  aborted;
        for (int k = 0; k < r * 32; k++) sb.push_back(pat(k % 32));
        for (int k = 0; k < 64; k++) sb.push_back(32'h0);
        start = 1'b1;
        reps  = 8'(r);
        step();
        start = 1'b0;
        reps  = 8'hAA;
        check({tag, "_load_status"}, status(), 32'h6);
        duc_in_strobe = 1'b1;  // must be ignored in LOAD
        step();
        cyc = 0; strobes = 0; fin = 1'b0; aborted = 1'b0;
        while (!fin && cyc < 2000) begin
            duc_in_strobe = ((cyc % stride) == 0);
            check({tag, "_busy"}, status(), 32'h6);
            if (sb.size() == 0) begin
                check({tag, "_overrun"}, 32'h1, 32'h0);
                fin = 1'b1;
            end else begin
                check({tag, "_sample"}, duc_in_sample, sb[0]);
                if (duc_in_strobe) begin
                    void'(sb.pop_front());
                    strobes++;
                end
                if (poke && cyc == 20) begin
                    start    = 1'b1;
                    reps     = 8'd5;
                    cfg_we   = 1'b1;
                    cfg_addr = 5'd0;
                    cfg_data = 32'hDEADBEEF;
                end
                if (abort_at != 0 && strobes == abort_at && duc_in_strobe) abort = 1'b1;
                step();
                start  = 1'b0;
                cfg_we = 1'b0;
                if (abort) begin
                    abort   = 1'b0;
                    aborted = 1'b1;
                    fin     = 1'b1;
                end else if (sb.size() == 0) begin
                    fin = 1'b1;
                end
            end
            cyc++;
        end
        duc_in_strobe = 1'b0;
        if (!fin) check({tag, "_timeout"}, 32'h1, 32'h0);
        if (aborted) begin
            check({tag, "_abort_status"}, status(), 32'h0);
            check({tag, "_abort_sample"}, duc_in_sample, 32'h0);
            sb.delete();
        end else begin
            check({tag, "_done_status"}, status(), 32'h1);
            check({tag, "_done_sample"}, duc_in_sample, 32'h0);
        end
        step();
        check({tag, "_idle_after"}, status(), 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; reps = '0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; use_lfsr = 1'b0; duc_in_strobe = 1'b0;
        repeat (3) step();
        check("reset_status", status(), 32'h0);
        check("reset_sample", duc_in_sample, 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 32; i++) begin
            cfg_we = 1'b1; cfg_addr = 5'(i); cfg_data = pat(i);
            step();
        end
        cfg_we = 1'b0;
        step();

        run_burst(2, 1, 0, 1'b0, "reps2_stride1");
        run_burst(2, 3, 0, 1'b1, "reps2_stride3_poke");
        run_burst(1, 1, 0, 1'b0, "ram0_intact");
        run_burst(0, 1, 0, 1'b0, "reps0");
        run_burst(2, 1, 42, 1'b0, "abort_rep1");
        run_burst(1, 2, 0, 1'b0, "replay");

        start = 1'b1; abort = 1'b1; reps = 8'd2;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle0", status(), 32'h0);
        step();
        check("start_abort_idle1", status(), 32'h0);
        check("start_abort_sample", duc_in_sample, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
